// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronises and deglitches the pins, deframes 11-bit frames and
// folds set-2 E0/F0 prefixes into single key events with one-cycle strobes.
`timescale 1ns/1ps

module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       KEY_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       KEY_RELEASED,
    output logic       FRAME_ERROR
);

    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]     FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     BYTE_EXT  = 8'hE0;
    localparam logic [7:0]     BYTE_REL  = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Synchroniser and filter state
    logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic           filt_clk_q, filt_clk_d;
    logic           filt_prev_q;
    logic [3:0]     filt_cnt_q, filt_cnt_d;
    logic           fall;

    // Frame deframer state
    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           byte_good;

    // Prefix flags and registered outputs
    logic           ext_q, ext_d;
    logic           rel_q, rel_d;
    logic           key_valid_q, key_valid_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_ext_q, key_ext_d;
    logic           key_rel_q, key_rel_d;
    logic           frame_error_q, frame_error_d;

    // The filtered clock only flips after FILTER_LEN straight cycles of disagreement.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        tmo_d         = tmo_q;
        byte_good     = 1'b0;
        frame_error_d = 1'b0;

        if (state_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d         = '0;
            state_d       = S_IDLE;
            frame_error_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TCW'(1);
        end

        if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = data_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    if (data_s2_q && (^{shift_q, par_q})) begin
                        byte_good = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ext_d       = ext_q;
        rel_d       = rel_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_rel_d   = key_rel_q;

        if (frame_error_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_good) begin
            if (shift_q == BYTE_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == BYTE_REL) begin
                rel_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = shift_q;
                key_ext_d   = ext_q;
                key_rel_d   = rel_q;
                ext_d       = 1'b0;
                rel_d       = 1'b0;
            end
        end
    end

    // Pins idle high, so the synchronisers and filter reset to 1 to avoid a false edge.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            data_s1_q     <= 1'b1;
            data_s2_q     <= 1'b1;
            filt_clk_q    <= 1'b1;
            filt_prev_q   <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            tmo_q         <= '0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_ext_q     <= 1'b0;
            key_rel_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            clk_s1_q      <= PS2_CLK;
            clk_s2_q      <= clk_s1_q;
            data_s1_q     <= PS2_DATA;
            data_s2_q     <= data_s1_q;
            filt_clk_q    <= filt_clk_d;
            filt_prev_q   <= filt_clk_q;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tmo_q         <= tmo_d;
            ext_q         <= ext_d;
            rel_q         <= rel_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_rel_q     <= key_rel_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign KEY_VALID    = key_valid_q;
    assign KEY_CODE     = key_code_q;
    assign KEY_EXTENDED = key_ext_q;
    assign KEY_RELEASED = key_rel_q;
    assign FRAME_ERROR  = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: make/break/extended codes, parity error, timeout,
// glitch rejection and mid-frame reset.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

    localparam int TIMEOUT  = 5000;
    localparam int SLOW_H   = 1000;  // half bit at 12.5 kHz with a 25 MHz clock
    localparam int FAST_H   = 20;

    logic       CLK_25MHZ = 1'b0;
    logic       RESET     = 1'b1;
    logic       PS2_CLK   = 1'b1;
    logic       PS2_DATA  = 1'b1;
    logic       KEY_VALID;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED;
    logic       KEY_RELEASED;
    logic       FRAME_ERROR;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int last_drop = 0;
    int kv_count = 0, fe_count = 0;
    int kv_cyc = 0, fe_cyc = 0;
    int both_seen = 0, kv_long = 0, fe_long = 0;
    logic kv_prev = 1'b0, fe_prev = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK_25MHZ   (CLK_25MHZ),
        .RESET       (RESET),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .KEY_VALID   (KEY_VALID),
        .KEY_CODE    (KEY_CODE),
        .KEY_EXTENDED(KEY_EXTENDED),
        .KEY_RELEASED(KEY_RELEASED),
        .FRAME_ERROR (FRAME_ERROR)
    );

    always #20 CLK_25MHZ = ~CLK_25MHZ;

    always @(posedge CLK_25MHZ) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling clock edge.
    always @(negedge CLK_25MHZ) begin
        if (KEY_VALID) begin
            kv_count = kv_count + 1;
            kv_cyc   = cyc;
        end
        if (FRAME_ERROR) begin
            fe_count = fe_count + 1;
            fe_cyc   = cyc;
        end
        if (KEY_VALID && FRAME_ERROR) both_seen = both_seen + 1;
        if (KEY_VALID && kv_prev)     kv_long   = kv_long + 1;
        if (FRAME_ERROR && fe_prev)   fe_long   = fe_long + 1;
        kv_prev = KEY_VALID;
        fe_prev = FRAME_ERROR;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK_25MHZ);
        #1;
    endtask

    task automatic send_bit(input logic v, input int half);
        PS2_DATA = v;
        wait_cycles(half);
        PS2_CLK   = 1'b0;
        last_drop = cyc;
        wait_cycles(half);
        PS2_CLK = 1'b1;
    endtask

    // Sends the first nbits of a frame (11 for a complete frame).
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int half,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], half);
        PS2_DATA = 1'b1;
        wait_cycles(half);
    endtask

    task automatic expect_event(input string name, input int kv_delta, input logic [7:0] code,
                                input logic ext, input logic rel, input int kv0);
        checks++;
        if (kv_count - kv0 !== kv_delta) begin
            $display("FAIL %s key_valid pulses: got %0d expected %0d", name, kv_count - kv0, kv_delta);
            errors++;
        end
        checks++;
        if (KEY_CODE !== code) begin
            $display("FAIL %s KEY_CODE: got %02h expected %02h", name, KEY_CODE, code);
            errors++;
        end
        checks++;
        if (KEY_EXTENDED !== ext) begin
            $display("FAIL %s KEY_EXTENDED: got %b expected %b", name, KEY_EXTENDED, ext);
            errors++;
        end
        checks++;
        if (KEY_RELEASED !== rel) begin
            $display("FAIL %s KEY_RELEASED: got %b expected %b", name, KEY_RELEASED, rel);
            errors++;
        end
    endtask

    task automatic expect_fe(input string name, input int fe_delta, input int fe0);
        checks++;
        if (fe_count - fe0 !== fe_delta) begin
            $display("FAIL %s frame_error pulses: got %0d expected %0d", name, fe_count - fe0, fe_delta);
            errors++;
        end
    endtask

    task automatic expect_all_zero(input string name);
        checks++;
        if ({KEY_VALID, KEY_CODE, KEY_EXTENDED, KEY_RELEASED, FRAME_ERROR} !== 12'h000) begin
            $display("FAIL %s outputs: got valid=%b code=%02h ext=%b rel=%b ferr=%b expected all 0",
                     name, KEY_VALID, KEY_CODE, KEY_EXTENDED, KEY_RELEASED, FRAME_ERROR);
            errors++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        wait_cycles(5);
        expect_all_zero("reset_hold");
        RESET = 1'b0;
        wait_cycles(20);
        expect_all_zero("reset_release_idle");
    endtask

    task automatic test_make_code();
        int kv0 = kv_count, fe0 = fe_count;
        send_frame(8'h1C, 1'b0, SLOW_H, 11);
        expect_event("make_1c", 1, 8'h1C, 1'b0, 1'b0, kv0);
        expect_fe("make_1c", 0, fe0);
        // Stop-bit drop to strobe: 2 sync + 4 filter + edge detect + output register.
        checks++;
        if (kv_cyc - last_drop < 5 || kv_cyc - last_drop > 10) begin
            $display("FAIL make_latency: got %0d cycles expected 5..10", kv_cyc - last_drop);
            errors++;
        end
    endtask

    task automatic test_break_code();
        int kv0 = kv_count;
        send_frame(8'hF0, 1'b0, FAST_H, 11);
        expect_event("break_after_f0", 0, 8'h1C, 1'b0, 1'b0, kv0);
        kv0 = kv_count;
        send_frame(8'h1C, 1'b0, FAST_H, 11);
        expect_event("break_1c", 1, 8'h1C, 1'b0, 1'b1, kv0);
        kv0 = kv_count;
        send_frame(8'h1C, 1'b0, FAST_H, 11);
        expect_event("make_after_break", 1, 8'h1C, 1'b0, 1'b0, kv0);
    endtask

    task automatic test_extended_break();
        int kv0 = kv_count, fe0 = fe_count;
        send_frame(8'hE0, 1'b0, FAST_H, 11);
        send_frame(8'hF0, 1'b0, FAST_H, 11);
        send_frame(8'h6B, 1'b0, FAST_H, 11);
        expect_event("ext_break_6b", 1, 8'h6B, 1'b1, 1'b1, kv0);
        expect_fe("ext_break_6b", 0, fe0);
    endtask

    task automatic test_parity_error();
        int kv0 = kv_count, fe0 = fe_count;
        send_frame(8'hE0, 1'b0, FAST_H, 11);
        send_frame(8'h1C, 1'b1, FAST_H, 11);
        expect_event("bad_parity", 0, 8'h6B, 1'b1, 1'b1, kv0);
        expect_fe("bad_parity", 1, fe0);
        kv0 = kv_count;
        send_frame(8'h29, 1'b0, FAST_H, 11);
        expect_event("recover_29", 1, 8'h29, 1'b0, 1'b0, kv0);
    endtask

    task automatic test_timeout();
        int kv0 = kv_count, fe0 = fe_count;
        int waited = 0;
        send_frame(8'h1C, 1'b0, FAST_H, 4);
        while (fe_count == fe0 && waited < TIMEOUT + 1000) begin
            wait_cycles(1);
            waited++;
        end
        checks++;
        if (fe_count == fe0) begin
            $display("FAIL timeout_wait: no frame_error within %0d cycles", waited);
            errors++;
        end else begin
            checks++;
            if (fe_cyc - last_drop < TIMEOUT + 4 || fe_cyc - last_drop > TIMEOUT + 10) begin
                $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d",
                         fe_cyc - last_drop, TIMEOUT + 4, TIMEOUT + 10);
                errors++;
            end
        end
        wait_cycles(5);
        expect_fe("timeout_single", 1, fe0);
        checks++;
        if (kv_count !== kv0) begin
            $display("FAIL timeout_no_valid: got %0d pulses expected 0", kv_count - kv0);
            errors++;
        end
        kv0 = kv_count;
        send_frame(8'h1C, 1'b0, FAST_H, 11);
        expect_event("after_timeout_1c", 1, 8'h1C, 1'b0, 1'b0, kv0);
    endtask

    task automatic test_glitch();
        int kv0 = kv_count, fe0 = fe_count;
        PS2_DATA = 1'b0;
        PS2_CLK  = 1'b0;
        wait_cycles(2);
        PS2_CLK = 1'b1;
        wait_cycles(FAST_H);
        PS2_DATA = 1'b1;
        wait_cycles(FAST_H);
        expect_event("glitch_ignored", 0, 8'h1C, 1'b0, 1'b0, kv0);
        send_frame(8'h29, 1'b0, FAST_H, 11);
        expect_event("after_glitch_29", 1, 8'h29, 1'b0, 1'b0, kv0);
        expect_fe("after_glitch", 0, fe0);
    endtask

    task automatic test_reset_mid_frame();
        int kv0, fe0;
        send_frame(8'hE0, 1'b0, FAST_H, 11);
        send_frame(8'hF0, 1'b0, FAST_H, 11);
        send_frame(8'h75, 1'b0, FAST_H, 11);
        kv0 = kv_count;
        expect_event("pre_reset_75", 0, 8'h75, 1'b1, 1'b1, kv0);
        send_frame(8'h1C, 1'b0, FAST_H, 6);
        RESET = 1'b1;
        #1;
        expect_all_zero("reset_mid_frame");
        wait_cycles(4);
        RESET = 1'b0;
        fe0 = fe_count;
        kv0 = kv_count;
        wait_cycles(50);
        expect_fe("reset_discard", 0, fe0);
        send_frame(8'h1C, 1'b0, FAST_H, 11);
        expect_event("after_reset_1c", 1, 8'h1C, 1'b0, 1'b0, kv0);
        expect_fe("after_reset_1c", 0, fe0);
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (both_seen !== 0) begin
            $display("FAIL strobe_overlap: got %0d cycles expected 0", both_seen);
            errors++;
        end
        checks++;
        if (kv_long !== 0) begin
            $display("FAIL key_valid_width: got %0d extra cycles expected 0", kv_long);
            errors++;
        end
        checks++;
        if (fe_long !== 0) begin
            $display("FAIL frame_error_width: got %0d extra cycles expected 0", fe_long);
            errors++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_make_code();
        test_break_code();
        test_extended_break();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_strobe_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage feeding the game core's keyboard input.
- Receives raw PS/2 clock/data lines from the Nexys A7 connector and synchronises and deglitches them.
- Deframes 11-bit PS/2 device-to-host frames.
- Folds set-2 prefix bytes (E0 extended, F0 break) into single key events with a one-cycle valid strobe for the game's input logic.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised PS2_CLK samples required before the filtered clock changes (range 1..15)
TIMEOUT_CYCLES, 5000, CLK_25MHZ cycles with no filtered falling edge mid-frame before the frame is aborted (200 us at 25 MHz)

Ports:
CLK_25MHZ  input  1  system clock, 25 MHz pixel clock domain
RESET  input  1  asynchronous, active-high reset
PS2_CLK  input  1  raw PS/2 clock from pin, asynchronous
PS2_DATA  input  1  raw PS/2 data from pin, asynchronous
KEY_VALID  output  1  one-cycle strobe: new key event on KEY_* outputs
KEY_CODE  output  8  scan code (non-prefix byte) of last event
KEY_EXTENDED  output  1  last event was preceded by E0
KEY_RELEASED  output  1  last event was preceded by F0 (break)
FRAME_ERROR  output  1  one-cycle strobe: parity/stop error or timeout

Behaviour:
Reset:
- One clock, CLK_25MHZ; RESET is asynchronous and active-high, clears everything.
- All outputs 0; synchroniser flops and filtered clock reset to 1; FSM IDLE; prefix flags cleared.
- RESET asserted mid-frame discards the partial frame with no strobe.

Synchronise/filter:
- Two-flop synchroniser on each input.
- Filtered clock takes the synchronised PS2_CLK value only after FILTER_LEN consecutive cycles of agreement; the counter clears on any disagreement.
- Falling edge = filtered previous 1, current 0.
- Data is sampled from synchronised PS2_DATA in the edge cycle.

Frame FSM (advances only on falling edges, except timeout):
- IDLE: data 0 -> DATA, bit count 0; data 1 -> stay IDLE (no error).
- DATA: shift in LSB-first; after 8th bit -> PARITY.
- PARITY: capture bit -> STOP.
- STOP: frame good iff stop bit = 1 and XOR(8 data bits, parity) = 1 (odd parity). Good -> internal byte strobe; bad -> FRAME_ERROR. Either way -> IDLE.
- Timeout counter clears on every falling edge and in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 -> IDLE plus FRAME_ERROR pulse.

Prefix/event logic (on good byte):
- 0xE0 -> set ext flag, no strobe.
- 0xF0 -> set rel flag, no strobe.
- Any other byte (including 0xE1, 0xAA, 0xFA) -> KEY_VALID for exactly 1 cycle; KEY_CODE/KEY_EXTENDED/KEY_RELEASED load byte/ext/rel; both flags clear.
- Any FRAME_ERROR also clears both flags.
- KEY_CODE/KEY_EXTENDED/KEY_RELEASED hold between events.

Timing and strobes:
- Latency: KEY_VALID / FRAME_ERROR registered, high on the clock edge after the cycle in which the stop-bit falling edge (or timeout terminal count) is detected.
- KEY_VALID and FRAME_ERROR are never high together; neither is ever high for more than 1 cycle.
- Host-to-device (inhibit) signalling is not supported: PS2_CLK held low longer than a bit time simply delays the next edge.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> single KEY_VALID pulse; KEY_CODE=0x1C, KEY_EXTENDED=0, KEY_RELEASED=0; FRAME_ERROR never high.
- Bytes F0,1C -> no strobe after F0; one KEY_VALID with KEY_CODE=0x1C, RELEASED=1, EXTENDED=0. A following 0x1C frame gives RELEASED=0.
- Bytes E0,F0,6B -> exactly one KEY_VALID; KEY_CODE=0x6B, EXTENDED=1, RELEASED=1.
- Parity fault and recovery:
  - E0, then 0x1C with parity 1 -> FRAME_ERROR 1-cycle pulse, no KEY_VALID.
  - Next good 0x29 -> KEY_CODE=0x29, EXTENDED=0 (flag cleared).
- Timeout: start bit + 3 data bits, then PS2_CLK held high -> FRAME_ERROR pulses exactly TIMEOUT_CYCLES cycles after the last filtered edge (±2 sync/filter cycles). Subsequent full 0x1C frame decodes correctly.
- Glitch and reset:
  - 2-cycle low pulse on PS2_CLK in IDLE with FILTER_LEN=4 -> no state change, no strobes.
  - RESET asserted after 5 data bits -> all outputs 0 immediately. Next clean 0x1C frame decodes correctly.
